// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier (MULT unit, EX stage).
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int BOOTH_WIDTH = 32;

  // The step counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int BOOTH_CNT_W = cnt_width(BOOTH_WIDTH);

endpackage

// File: rtl/booth_multiplier_step.sv
// One combinational radix-2 Booth iteration: conditional add/subtract of M into A,
// then arithmetic right shift of {A, Q, Q-1} by one bit.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             q_m1_nxt
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    case ({q[0], q_m1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  assign acc_nxt  = {sum[WIDTH], sum[WIDTH:1]};
  assign q_nxt    = {sum[0], q[WIDTH-1:1]};
  assign q_m1_nxt = q[0];

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier, WIDTH cycles per product, busy drives the pipeline stall.
// Optional BOOTH_ZERO_SKIP_EN: a zero operand completes in one cycle without asserting busy.
module booth_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH:0]   acc, acc_nxt, m_reg;
  logic [WIDTH-1:0] q, q_nxt;
  logic             q_m1, q_m1_nxt;
  logic [CW-1:0]    cnt;
  logic             accept, last_step, zero_op;

`ifdef BOOTH_ZERO_SKIP_EN
  assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign accept    = start && !flush && (state != ST_RUN);
  assign last_step = (cnt == CW'(1));

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .q        (q),
    .q_m1     (q_m1),
    .m        (m_reg),
    .acc_nxt  (acc_nxt),
    .q_nxt    (q_nxt),
    .q_m1_nxt (q_m1_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = zero_op ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_step) state_nxt = ST_DONE;
      ST_DONE: state_nxt = accept ? (zero_op ? ST_DONE : ST_RUN) : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // Flush overrides everything, including a simultaneous start.
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_RUN);
      done  <= (state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      m_reg   <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      acc   <= '0;
      q     <= multiplier;
      q_m1  <= 1'b0;
      m_reg <= {multiplicand[WIDTH-1], multiplicand};
      cnt   <= CW'(WIDTH);
      if (zero_op) product <= '0;
    end else if (state == ST_RUN && !flush) begin
      acc  <= acc_nxt;
      q    <= q_nxt;
      q_m1 <= q_m1_nxt;
      cnt  <= cnt - CW'(1);
      // The extra A bit is only guard headroom; the product fits in 2*WIDTH bits.
      if (last_step) product <= {acc_nxt[WIDTH-1:0], q_nxt};
    end
  end

endmodule
